// File: rtl/conv_window_gen.sv
// Streaming K-row window generator: emits one vertical K-pixel column per accepted pixel for the convolution engine.
// Optional build macro CONV_WIN_TOPPAD_EN: columns valid from row 0 with zero-padded upper lanes.
module conv_window_gen #(
    parameter int K      = 5,
    parameter int DW     = 8,
    parameter int NI_MAX = 28
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_start,
    input  logic              i_state,
    input  logic [DW-1:0]     i_din,
    input  logic              i_din_valid,
    output logic [K*DW-1:0]   o_taps,
    output logic              o_tvalid,
    output logic [4:0]        o_tcol,
    output logic              o_frame_done
);

    logic              r_start_d;
    logic              r_is12;
    logic [4:0]        r_col;
    logic [4:0]        r_row;
    logic [DW-1:0]     r_lb [K-1][NI_MAX];

    logic              w_rise;
    logic              w_is12;
    logic [4:0]        w_nim1;
    logic              w_accept;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_col_valid;
    logic [K*DW-1:0]   w_taps;

    // Layer size is taken from i_state on the very cycle start rises so a pixel on that cycle already uses it.
    always_comb begin
        w_rise      = i_start & ~r_start_d;
        w_is12      = w_rise ? i_state : r_is12;
        w_nim1      = w_is12 ? 5'd11 : 5'd27;
        w_accept    = i_start & i_din_valid;
        w_col_last  = (r_col == w_nim1);
        w_row_last  = (r_row == w_nim1);
`ifdef CONV_WIN_TOPPAD_EN
        w_col_valid = 1'b1;
`else
        w_col_valid = (r_row >= 5'(K-1));
`endif
    end

    // Column assembly: lane 0 is the live pixel, lane k is the line buffer k-1 rows older.
    always_comb begin
        w_taps = '0;
        w_taps[DW-1:0] = i_din;
        for (int k = 1; k < K; k++) begin
`ifdef CONV_WIN_TOPPAD_EN
            if (r_row < 5'(k)) begin
                w_taps[k*DW +: DW] = '0;
            end else begin
                w_taps[k*DW +: DW] = r_lb[k-1][r_col];
            end
`else
            w_taps[k*DW +: DW] = r_lb[k-1][r_col];
`endif
        end
    end

    // Counters, layer latch and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_start_d    <= 1'b0;
            r_is12       <= 1'b0;
            r_col        <= 5'd0;
            r_row        <= 5'd0;
            o_taps       <= '0;
            o_tvalid     <= 1'b0;
            o_tcol       <= 5'd0;
            o_frame_done <= 1'b0;
        end else begin
            r_start_d <= i_start;
            if (w_rise) begin
                r_is12 <= i_state;
            end else begin
                r_is12 <= r_is12;
            end
            if (!i_start) begin
                r_col        <= 5'd0;
                r_row        <= 5'd0;
                o_taps       <= '0;
                o_tvalid     <= 1'b0;
                o_tcol       <= 5'd0;
                o_frame_done <= 1'b0;
            end else if (i_din_valid) begin
                o_taps       <= w_taps;
                o_tvalid     <= w_col_valid;
                o_tcol       <= r_col;
                o_frame_done <= w_col_last & w_row_last;
                if (w_col_last) begin
                    r_col <= 5'd0;
                    r_row <= w_row_last ? 5'd0 : r_row + 5'd1;
                end else begin
                    r_col <= r_col + 5'd1;
                end
            end else begin
                o_tvalid     <= 1'b0;
                o_frame_done <= 1'b0;
            end
        end
    end

    // Line buffers shift down one row at the current column; contents are never cleared, row gating masks stale data.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb[0][r_col] <= i_din;
            for (int k = 1; k < K-1; k++) begin
                r_lb[k][r_col] <= r_lb[k-1][r_col];
            end
        end
    end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 5-row window generator that feeds the binary convolution engine. It accepts one 8-bit pixel per valid cycle in raster order for a square Ni×Ni feature map, with Ni = 28 for layer 1 and 12 for layer 2. Four internal line buffers hold the previous rows. Each cycle it emits one vertical 5-pixel column on `taps[39:0]`; the convolution engine shifts these columns into its own 5×5 register window. It sits between the feature-map reader (or the layer-1 pooling output) and the convolution engine.

## Interface
- `K`, 5, kernel height; number of lanes in `taps`.
- `DW`, 8, pixel width in bits.
- `NI_MAX`, 28, line-buffer depth in pixels.
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  reset: asynchronous, active-low.
- `start`  in  1  level enable; low synchronously clears counters and outputs.
- `state`  in  1  layer select: 0 → Ni=28, 1 → Ni=12. Sampled on the cycle `start` goes 0→1.
- `din`  in  8  pixel, signed sign-magnitude byte, passed through unmodified.
- `din_valid`  in  1  `din` is accepted this cycle when `start`=1.
- `taps`  out  40  window column: `[39:32]` row r-4 (oldest), `[31:24]` r-3, `[23:16]` r-2, `[15:8]` r-1, `[7:0]` row r (current `din`).
- `tvalid`  out  1  `taps` holds a valid column.
- `tcol`  out  5  column index of the current `taps` column (0..Ni-1).
- `frame_done`  out  1  one-cycle pulse, concurrent with the column for the last frame pixel.

## Operation
- Counters:
  - `col` runs 0..Ni-1 and `row` runs 0..Ni-1, both 5 bits.
  - Both advance only on accepted pixels (`start` && `din_valid`).
  - `col` wraps to 0 at Ni-1 and increments `row`. At row Ni-1, col Ni-1 both wrap to 0, ready for the next frame.
- Line buffers:
  - Four buffers lb0..lb3, each NI_MAX×8, addressed by `col`.
  - On an accepted pixel the output is `taps`={lb3[col], lb2[col], lb1[col], lb0[col], din}.
  - On the same edge the buffers update: lb0[col]←din, lb1[col]←lb0[col], lb2[col]←lb1[col], lb3[col]←lb2[col].
  - Only entries 0..Ni-1 are used.
- Validity:
  - `tvalid`=1 for accepted pixels with `row` ≥ K-1 (4).
  - Rows 0-3 only prime the buffers.
- Ni latch: Ni is captured on the 0→1 edge of `start`. Changes on `state` while `start`=1 are ignored.
- Frame end: `frame_done`=1 with the column of pixel (Ni-1, Ni-1). The next frame starts priming again from row 0, and stale buffer content is masked by the row gating.
- Buffer contents are never cleared. Correctness relies only on the row gating.

## Timing
- Reset values: `taps`=0, `tvalid`=0, `tcol`=0, `frame_done`=0, `col`=`row`=0, Ni=28.
- Latency is 1 cycle. A pixel accepted at edge N produces `taps`/`tvalid`/`tcol` registered at edge N.
- Bubble (`din_valid`=0): `tvalid`=0 and `frame_done`=0 next cycle; `taps` and `tcol` hold; counters hold.
- `start`=0: counters clear and outputs go to 0 next edge. `din_valid` is ignored. If `start` falls while `din_valid`=1, start wins and the pixel is dropped.
- `start` falling mid-frame: the partial frame is abandoned. On restart, rows 0-3 prime again and no `tvalid` occurs before row 4.
- `rstn` asserted mid-operation: all registers return to reset values immediately.
- Throughput: one column per clock, with no backpressure. The downstream engine must accept every `tvalid` column.
- Columns per frame: Ni=28 gives (28-4)×28 = 672 valid columns; Ni=12 gives 8×12 = 96.

## Configuration
- `CONV_WIN_TOPPAD_EN` defined:
  - `tvalid`=1 for every accepted pixel from row 0, giving Ni×Ni columns per frame.
  - Lanes referencing rows <0 are forced to 0: lane `[39:32]` is zeroed when `row`<4, `[31:24]` when `row`<3, `[23:16]` when `row`<2, and `[15:8]` when `row`<1.
- Not defined: behaviour as in Operation, with raw lanes and `tvalid` only for `row`≥4.

## Test plan
- Ni=28, pixel(r,c)=(28r+c) mod 256, `din_valid` continuous:
  - First `tvalid` at pixel (4,0) with `taps`=0x00_1C_38_54_70 and `tcol`=0.
  - Exactly 672 `tvalid` columns.
  - `frame_done` with `taps`=0x9F_BB_D7_F3_0F.
- Ni=12 (`state`=1 at start), same pattern with 12r+c:
  - First valid `taps`=0x00_0C_18_24_30.
  - 96 valid columns.
  - `frame_done` with the column of pixel (11,11).
- Ni=28 with `din_valid` toggled pseudo-randomly at ~50%: the valid-column sequence is identical to the continuous run, and `tvalid` never asserts on bubble cycles.
- `start` dropped after pixel 300, then raised with a new frame: outputs are 0 the cycle after the drop, and no `tvalid` appears until new pixel (4,0), whose `taps` match the new frame.
- Two back-to-back Ni=28 frames: the second frame's first valid column has no contamination from frame 1, and 1344 valid columns are seen in total.
- `CONV_WIN_TOPPAD_EN` defined, Ni=28:
  - Pixel (0,0) gives `tvalid`=1 with `taps`=0x00_00_00_00_00.
  - Pixel (1,0) gives `taps`=0x00_00_00_00_1C.
  - 784 valid columns.
  - `rstn` pulse mid-frame returns all outputs to 0.
